// File: rtl/keypad_entry_ctrl_pkg.sv
// keypad_entry_ctrl_pkg
//   Shared keypad definitions: key-code constants from the keypad scanner,
//   entry-controller state encodings and a small key classification helper.
//   No ports.
package keypad_entry_ctrl_pkg;

  // Key codes as produced by the keypad scanner
  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;  // backspace
  localparam logic [3:0] KEY_B = 4'hB;  // clear
  localparam logic [3:0] KEY_C = 4'hC;  // unused
  localparam logic [3:0] KEY_D = 4'hD;  // unused
  localparam logic [3:0] KEY_E = 4'hE;  // enter
  localparam logic [3:0] KEY_F = 4'hF;  // unused

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_DONE  = 1'b1
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= KEY_9);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if
//   Bundles the scanner/consumer side of the keypad entry controller.
//   key, pressed : from the keypad scanner
//   ack          : consumer acknowledge of a completed entry
//   digits       : entry buffer, newest digit in [3:0]
//   digit_count  : number of valid digits
//   valid        : completed entry available
//   err          : one-cycle pulse on a rejected key event
//   master = scanner/consumer side, slave = controller side.
interface keypad_entry_ctrl_if #(
  parameter int MAX_DIGITS = 4
);
  logic [3:0]              key;
  logic                    pressed;
  logic                    ack;
  logic [4*MAX_DIGITS-1:0] digits;
  logic [2:0]              digit_count;
  logic                    valid;
  logic                    err;

  modport master (
    output key, pressed, ack,
    input  digits, digit_count, valid, err
  );

  modport slave (
    input  key, pressed, ack,
    output digits, digit_count, valid, err
  );
endinterface

// File: rtl/keypad_entry_ctrl_key_edge_det.sv
// key_edge_det
//   Rising-edge detector on the scanner pressed level, so a press held for the
//   whole scanner pause yields a single key event.
//   clk       : clock
//   rst       : async active-high reset
//   pressed   : scanner pressed level
//   key_event : pressed & ~pressed_d (named key_event since 'event' is a
//               reserved word)
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pressed,
  output logic key_event
);
  logic pressed_d;

  // Cleared in reset so a press held across reset release still fires once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pressed_d <= 1'b0;
    else     pressed_d <= pressed;
  end

  assign key_event = pressed & ~pressed_d;
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Collects keypad digits into a shift buffer with backspace/clear/enter,
//   then holds the completed entry until the consumer acknowledges it.
//   clk : clock, rising edge
//   rst : async active-high reset
//   bus : keypad_entry_ctrl_if.slave (key, pressed, ack in; digits,
//         digit_count, valid, err out)
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_entry_ctrl_if.slave    bus
);
  localparam int         DW      = 4*MAX_DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  entry_state_t    state, nxt_state;
  logic [DW-1:0]   digits, nxt_digits;
  logic [2:0]      count, nxt_count;
  logic            err, nxt_err;
  logic            key_event;

  key_edge_det u_edge (
    .clk       (clk),
    .rst       (rst),
    .pressed   (bus.pressed),
    .key_event (key_event)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_ENTRY;
      digits <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= nxt_state;
      digits <= nxt_digits;
      count  <= nxt_count;
      err    <= nxt_err;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_digits = digits;
    nxt_count  = count;
    nxt_err    = 1'b0;
    case (state)
      ST_ENTRY: begin
        if (key_event) begin
          if (is_digit(bus.key)) begin
            if (count < MAX_CNT) begin
              nxt_digits = {digits[DW-5:0], bus.key};
              nxt_count  = count + 3'd1;
            end else begin
              nxt_err = 1'b1;
            end
          end else begin
            case (bus.key)
              KEY_A: begin
                if (count != 3'd0) begin
                  nxt_digits = {4'h0, digits[DW-1:4]};
                  nxt_count  = count - 3'd1;
                end else begin
                  nxt_err = 1'b1;
                end
              end
              KEY_B: begin
                nxt_digits = '0;
                nxt_count  = '0;
              end
              KEY_E: begin
                if (count != 3'd0) nxt_state = ST_DONE;
                else               nxt_err   = 1'b1;
              end
              default: ;  // C, D, F ignored silently
            endcase
          end
        end
      end
      ST_DONE: begin
        // Key events are dropped here; ack wins even if a key arrives with it.
        if (bus.ack) begin
          nxt_state  = ST_ENTRY;
          nxt_digits = '0;
          nxt_count  = '0;
        end
      end
      default: nxt_state = ST_ENTRY;
    endcase
  end

  assign bus.digits      = digits;
  assign bus.digit_count = count;
  assign bus.valid       = (state == ST_DONE);
  assign bus.err         = err;
endmodule
